// File: rtl/memory_flash_arbiter_pkg.sv
// Shared constants and state type for the two-requester on-chip flash arbiter.
// Flash geometry, the synthetic timeout read word and the arbiter FSM encoding live here.
package memory_flash_arbiter_pkg;

    localparam logic [18:0] ONCHIP_FLASH_END   = 19'h7FFFF;
    localparam int          FLASH_ADDR_W       = $bits(ONCHIP_FLASH_END);
    localparam int          FLASH_DATA_W       = 32;
    localparam logic [31:0] FLASH_TIMEOUT_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DRAIN
    } arb_state_e;

endpackage

// File: rtl/memory_flash_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the flash wrapper.
// slave = arbiter view, master = the surrounding fabric / flash wrapper view.
interface memory_flash_arbiter_if
    import memory_flash_arbiter_pkg::*;
#(
    parameter int ADDR_W = FLASH_ADDR_W,
    parameter int DATA_W = FLASH_DATA_W
);

    logic [1:0]          i_request;
    logic [2*ADDR_W-1:0] i_address;
    logic [1:0]          o_busy;
    logic [1:0]          o_ack;
    logic [DATA_W-1:0]   o_data;
    logic                o_error;
    logic                o_mem_request;
    logic [ADDR_W-1:0]   o_mem_address;
    logic                i_mem_busy;
    logic                i_mem_ack;
    logic [DATA_W-1:0]   i_mem_data;

    modport slave (
        input  i_request, i_address, i_mem_busy, i_mem_ack, i_mem_data,
        output o_busy, o_ack, o_data, o_error, o_mem_request, o_mem_address
    );

    modport master (
        output i_request, i_address, i_mem_busy, i_mem_ack, i_mem_data,
        input  o_busy, o_ack, o_data, o_error, o_mem_request, o_mem_address
    );

endinterface

// File: rtl/memory_flash_arbiter_rr.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to the requester that was not granted last time.
module memory_rr_arbiter2 (
    input  logic [1:0] request_i,
    input  logic       lastGrant_i,
    output logic       grant_o,
    output logic       valid_o
);

    assign valid_o = |request_i;
    assign grant_o = (request_i == 2'b11) ? ~lastGrant_i : request_i[1];

endmodule

// File: rtl/memory_flash_arbiter.sv
// Round-robin arbiter sharing the single-port flash reader between CPU (0) and PI (1) buses.
// Define FLASH_ARB_TIMEOUT_EN to add the WAIT_ACK timeout with synthetic error completion and DRAIN.
module memory_flash_arbiter
    import memory_flash_arbiter_pkg::*;
#(
    parameter int ADDR_W = FLASH_ADDR_W,
    parameter int DATA_W = FLASH_DATA_W
`ifdef FLASH_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    memory_flash_arbiter_if.slave bus
);

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count_q;
    logic             error_q;
`endif

    arb_state_e        state_q;
    logic              lastGrant_q;
    logic              grant_q;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] data_q;
    logic              memRequest_q;
    logic [ADDR_W-1:0] memAddress_q;
    logic              pick;
    logic              pickValid;
    logic              idleGrant;

    memory_rr_arbiter2 u_rr (
        .request_i   (bus.i_request),
        .lastGrant_i (lastGrant_q),
        .grant_o     (pick),
        .valid_o     (pickValid)
    );

    // Busy is combinational so the winner sees acceptance in the same cycle it requests.
    assign idleGrant     = (state_q == IDLE) && pickValid;
    assign bus.o_busy[0] = bus.i_request[0] && !(idleGrant && !pick);
    assign bus.o_busy[1] = bus.i_request[1] && !(idleGrant && pick);

    assign bus.o_ack         = ack_q;
    assign bus.o_data        = data_q;
    assign bus.o_mem_request = memRequest_q;
    assign bus.o_mem_address = memAddress_q;
`ifdef FLASH_ARB_TIMEOUT_EN
    assign bus.o_error = error_q;
`else
    assign bus.o_error = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            lastGrant_q  <= 1'b1;
            grant_q      <= 1'b0;
            ack_q        <= 2'b00;
            data_q       <= '0;
            memRequest_q <= 1'b0;
            memAddress_q <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
            error_q      <= 1'b0;
            count_q      <= '0;
`endif
        end else begin
            ack_q <= 2'b00;
`ifdef FLASH_ARB_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        grant_q      <= pick;
                        lastGrant_q  <= pick;
                        memAddress_q <= pick ? bus.i_address[2*ADDR_W-1:ADDR_W]
                                             : bus.i_address[ADDR_W-1:0];
                        memRequest_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.i_mem_busy) begin
                        memRequest_q <= 1'b0;
                        state_q      <= WAIT_ACK;
`ifdef FLASH_ARB_TIMEOUT_EN
                        count_q      <= '0;
`endif
                    end
                end
                WAIT_ACK: begin
                    // A real ack on the limit cycle still counts as a normal completion.
                    if (bus.i_mem_ack) begin
                        ack_q   <= grant_q ? 2'b10 : 2'b01;
                        data_q  <= bus.i_mem_data;
                        state_q <= IDLE;
                    end
`ifdef FLASH_ARB_TIMEOUT_EN
                    else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ack_q   <= grant_q ? 2'b10 : 2'b01;
                        data_q  <= DATA_W'(FLASH_TIMEOUT_DATA);
                        error_q <= 1'b1;
                        state_q <= DRAIN;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
`endif
                end
`ifdef FLASH_ARB_TIMEOUT_EN
                DRAIN: begin
                    if (bus.i_mem_ack) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_flash_arbiter.sv
// Directed and random checks of memory_flash_arbiter against a transaction-level model.
// Honours FLASH_ARB_TIMEOUT_EN (timeout shortened to 8 cycles for the timeout scenario).
module tb_memory_flash_arbiter;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic clk;
    logic rstN;

    memory_flash_arbiter_if #(.ADDR_W(19), .DATA_W(32)) bus ();

    memory_flash_arbiter #(
        .ADDR_W(19),
        .DATA_W(32)
`ifdef FLASH_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rstN),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks;
    int nFail;

    // Requester and flash drive values
    logic [1:0]  req;
    logic [18:0] reqAddr [2];
    logic        fBusy, fAck;
    logic [31:0] fData;

    // Stimulus knobs
    bit          rnd, manualFlash, silent, dropOnAccept, overrideData;
    logic [31:0] overrideWord;
    int          busyKnob, ackDelayKnob, busyLeft, ackWait;

    // Transaction-level reference model of the arbiter
    bit          mBusy, mIssue, mDrain, mOwner, mLast;
    int          mWait;
    logic [18:0] mAddr;
    logic [31:0] mData;
    logic [1:0]  mAckExp;
    logic        mErrExp;

    int          acc [2];
    int          ackCnt [2];
    int          memReads;

    function automatic logic [31:0] memWord(input logic [18:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000 ^ 32'(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveBus();
        bus.i_request  = req;
        bus.i_address  = {reqAddr[1], reqAddr[0]};
        bus.i_mem_busy = fBusy;
        bus.i_mem_ack  = fAck;
        bus.i_mem_data = fData;
    endtask

    task automatic modelReset();
        mBusy = 0; mIssue = 0; mDrain = 0; mOwner = 0; mLast = 1'b1;
        mWait = 0; mAddr = '0; mData = '0; mAckExp = 2'b00; mErrExp = 1'b0;
    endtask

    // One clock cycle: drive after a falling edge, check combinational outputs,
    // advance the model across the rising edge, then check registered outputs.
    task automatic applyStimulus();
        logic [1:0] expBusy;
        logic       g;
        bit         canAccept;
        if (rnd) begin
            for (int n = 0; n < 2; n++) begin
                if (!req[n]) begin
                    if ($urandom_range(2) == 0) begin
                        req[n]     = 1'b1;
                        reqAddr[n] = 19'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    req[n] = 1'b0;
                end
            end
        end
        if (!manualFlash) begin
            fAck  = 1'b0;
            fData = $urandom;
            fBusy = rnd ? ($urandom_range(2) == 0) : 1'b0;
            if (mBusy && mIssue) begin
                if (!rnd) begin
                    fBusy = (busyLeft > 0);
                    if (busyLeft > 0) busyLeft--;
                end
            end else if (mBusy && !mDrain) begin
                if (ackWait == 0 && !silent) begin
                    fAck  = 1'b1;
                    fData = overrideData ? overrideWord : memWord(mAddr);
                end else if (ackWait > 0) begin
                    ackWait--;
                end
            end else if (rnd && $urandom_range(7) == 0) begin
                fAck = 1'b1;
            end
        end
        driveBus();
        #1;
        g         = (req == 2'b11) ? ~mLast : req[1];
        canAccept = !mBusy && (req != 2'b00);
        expBusy   = req & ~(canAccept ? (g ? 2'b10 : 2'b01) : 2'b00);
        checkOutput("busy", bus.o_busy, expBusy);
        checkOutput("mem_request", bus.o_mem_request, mBusy && mIssue);
        checkOutput("mem_address", bus.o_mem_address, mAddr);
        if (bus.o_mem_request && !fBusy) memReads++;

        mAckExp = 2'b00;
        mErrExp = 1'b0;
        if (!rstN) begin
            modelReset();
        end else if (canAccept) begin
            mOwner = g; mLast = g; mAddr = reqAddr[g];
            mBusy = 1; mIssue = 1; busyLeft = busyKnob;
            acc[g]++;
            if (dropOnAccept) req[g] = 1'b0;
        end else if (mBusy && mIssue) begin
            if (!fBusy) begin
                mIssue  = 0;
                mWait   = 0;
                ackWait = rnd ? $urandom_range(3) : ackDelayKnob;
            end
        end else if (mBusy && mDrain) begin
            if (fAck) begin
                mBusy = 0; mDrain = 0;
            end
        end else if (mBusy) begin
            if (fAck) begin
                mAckExp = mOwner ? 2'b10 : 2'b01;
                mData   = fData;
                mBusy   = 0;
            end
`ifdef FLASH_ARB_TIMEOUT_EN
            else if (mWait == TMO - 1) begin
                mAckExp = mOwner ? 2'b10 : 2'b01;
                mErrExp = 1'b1;
                mData   = 32'hFFFF_FFFF;
                mDrain  = 1;
            end else begin
                mWait++;
            end
`endif
        end

        @(negedge clk);
        checkOutput("ack", bus.o_ack, mAckExp);
        checkOutput("data", bus.o_data, mData);
        checkOutput("error", bus.o_error, mErrExp);
        if (bus.o_ack[0]) ackCnt[0]++;
        if (bus.o_ack[1]) ackCnt[1]++;
    endtask

    task automatic runUntilAck(input string tag, input int maxSteps, output int steps);
        steps = 0;
        do begin
            applyStimulus();
            steps++;
        end while (bus.o_ack == 2'b00 && steps < maxSteps);
        checkOutput({tag, "_ack_seen"}, bus.o_ack != 2'b00, 1);
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        applyStimulus();
        rstN = 1'b1;
    endtask

    initial begin
        int steps;
        logic order [$];
        nChecks = 0; nFail = 0;
        rnd = 0; manualFlash = 0; silent = 0; dropOnAccept = 1; overrideData = 0;
        overrideWord = '0; busyKnob = 0; ackDelayKnob = 0; busyLeft = 0; ackWait = 0;
        acc[0] = 0; acc[1] = 0; ackCnt[0] = 0; ackCnt[1] = 0; memReads = 0;
        req = 2'b00; reqAddr[0] = '0; reqAddr[1] = '0;
        fBusy = 0; fAck = 0; fData = '0;
        rstN = 1'b0;
        driveBus();
        repeat (3) @(negedge clk);
        modelReset();
        rstN = 1'b1;
        checkOutput("reset_ack", bus.o_ack, 2'b00);
        checkOutput("reset_data", bus.o_data, 32'h0);
        checkOutput("reset_error", bus.o_error, 1'b0);
        checkOutput("reset_mem_request", bus.o_mem_request, 1'b0);
        checkOutput("reset_mem_address", bus.o_mem_address, 19'h0);

        // Scenario 1: lone CPU read, zero-wait flash answers with a fixed word
        overrideData = 1; overrideWord = 32'hDEADBEEF;
        req[0] = 1'b1; reqAddr[0] = 19'h00010;
        runUntilAck("t1", 10, steps);
        checkOutput("t1_latency", steps, 3);
        checkOutput("t1_ack", bus.o_ack, 2'b01);
        checkOutput("t1_data", bus.o_data, 32'hDEADBEEF);
        overrideData = 0;
        applyStimulus();
        checkOutput("t1_ack_clear", bus.o_ack, 2'b00);

        // Scenario 2: both requesters held high alternate 0,1,0,1
        resetDut();
        dropOnAccept = 0;
        reqAddr[0] = 19'h00100; reqAddr[1] = 19'h00200; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            runUntilAck("t2", 10, steps);
            order.push_back(bus.o_ack[1]);
            checkOutput("t2_data", bus.o_data, memWord(bus.o_ack[1] ? 19'h00200 : 19'h00100));
        end
        req = 2'b00; dropOnAccept = 1;
        checkOutput("t2_count", order.size(), 4);
        for (int k = 0; k < order.size(); k++) checkOutput("t2_order", order[k], k % 2);
        applyStimulus();

        // Scenario 3: flash stalls five cycles in ISSUE
        busyKnob = 5; memReads = 0;
        req[0] = 1'b1; reqAddr[0] = 19'h1ABCD;
        runUntilAck("t3", 20, steps);
        checkOutput("t3_ack", bus.o_ack, 2'b01);
        checkOutput("t3_latency", steps, 8);
        busyKnob = 0;
        applyStimulus();
        checkOutput("t3_reads", memReads, 1);

        // Scenario 4: reset while waiting, stale ack afterwards is dropped
        silent = 1;
        req[0] = 1'b1; reqAddr[0] = 19'h00444;
        for (int k = 0; k < 10 && !(mBusy && !mIssue); k++) applyStimulus();
        checkOutput("t4_waiting", mBusy && !mIssue, 1);
        applyStimulus();
        resetDut();
        manualFlash = 1; fBusy = 0; fAck = 0;
        applyStimulus();
        fAck = 1; fData = 32'h12345678;
        applyStimulus();
        checkOutput("t4_no_ack", bus.o_ack, 2'b00);
        fAck = 0; manualFlash = 0; silent = 0;
        req[1] = 1'b1; reqAddr[1] = 19'h059FF;
        runUntilAck("t4", 10, steps);
        checkOutput("t4_ack", bus.o_ack, 2'b10);
        checkOutput("t4_data", bus.o_data, memWord(19'h059FF));
        applyStimulus();

`ifdef FLASH_ARB_TIMEOUT_EN
        // Scenario 5: flash never answers, synthetic completion then drain
        silent = 1;
        req[0] = 1'b1; reqAddr[0] = 19'h00777;
        runUntilAck("t5", 40, steps);
        checkOutput("t5_latency", steps, TMO + 2);
        checkOutput("t5_error", bus.o_error, 1'b1);
        checkOutput("t5_data", bus.o_data, 32'hFFFF_FFFF);
        req[0] = 1'b1; reqAddr[0] = 19'h00888;
        repeat (3) applyStimulus();
        checkOutput("t5_drain_busy", bus.o_busy, 2'b01);
        manualFlash = 1; fBusy = 0; fAck = 1; fData = 32'hCAFEF00D;
        applyStimulus();
        manualFlash = 0; fAck = 0; silent = 0;
        runUntilAck("t5_next", 10, steps);
        checkOutput("t5_next_data", bus.o_data, memWord(19'h00888));
        checkOutput("t5_next_error", bus.o_error, 1'b0);
        applyStimulus();
`endif

        // Scenario 6: random traffic, every accept gets exactly one ack
        resetDut();
        acc[0] = 0; acc[1] = 0; ackCnt[0] = 0; ackCnt[1] = 0;
        rnd = 1;
        repeat (3000) applyStimulus();
        rnd = 0; req = 2'b00;
        for (int k = 0; k < 40 && mBusy; k++) applyStimulus();
        checkOutput("t6_idle", mBusy, 0);
        applyStimulus();
        checkOutput("t6_acks0", ackCnt[0], acc[0]);
        checkOutput("t6_acks1", ackCnt[1], acc[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
